// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Registers the EX bundle, runs at most one req/gnt/rvalid data-bus
// transaction per instruction, aligns/extends load data and drives the
// write-back bundle plus forwarding signals back to EX.
// Optional feature macro: MEM_MISALIGN_EXCP_EN (misaligned half/word
// accesses raise a flag and skip the bus; otherwise low address bits are
// masked to the access size).
module mem_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            EX_valid_i,
    input  logic [XLEN-1:0] EX_pc_i,
    input  logic [XLEN-1:0] ex_alu_res_i,
    input  logic [XLEN-1:0] ex_rs2_rdata_i,
    input  logic            ex_load_i,
    input  logic            ex_store_i,
    input  logic [1:0]      ex_size_i,
    input  logic            ex_unsigned_i,
    input  logic            ex_rd_wen_i,
    input  logic [4:0]      ex_rd_idx_i,
    input  logic            ex_excp_i,
    output logic            EX_ready_o,

    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    output logic [3:0]      dbus_wstrb_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    input  logic            dbus_err_i,

    output logic            MEM_valid_o,
    input  logic            WB_ready_i,
    output logic [XLEN-1:0] MEM_pc_o,
    output logic            MEM_rd_wen_o,
    output logic [4:0]      MEM_rd_idx_o,
    output logic [XLEN-1:0] MEM_alu_res_o,
    output logic [XLEN-1:0] MEM_rd_wdata_o,
    output logic            MEM_op_load_o,
    output logic            MEM_ld_misalign_o,
    output logic            MEM_st_misalign_o,
    output logic            MEM_bus_err_o
);

    localparam int unsigned SZ_BYTE = 0;
    localparam int unsigned SZ_HALF = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic            data_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] rs2_q;
    logic            load_q;
    logic            store_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            wen_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            capture;
    logic            go_bus;
    logic            mis_in;
    logic            rsp_accept;
    logic [1:0]      off;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_wstrb;
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_val;
    logic            mis_flag;

    assign EX_ready_o = !data_valid_q || ((state_q == S_DONE) && WB_ready_i);
    assign capture    = EX_ready_o && EX_valid_i;
    assign rsp_accept = dbus_rvalid_i &&
                        (((state_q == S_REQ) && dbus_gnt_i) || (state_q == S_WAIT));

`ifdef MEM_MISALIGN_EXCP_EN
    logic mis_q;

    assign mis_in = (ex_load_i || ex_store_i) &&
                    (((ex_size_i == 2'(SZ_HALF)) && ex_alu_res_i[0]) ||
                     ((ex_size_i == 2'd2) && (ex_alu_res_i[1:0] != 2'b00)));
    assign off      = alu_q[1:0];
    assign mis_flag = mis_q;

    // Misalignment flag captured alongside the bundle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          mis_q <= 1'b0;
        else if (capture) mis_q <= mis_in;
    end
`else
    assign mis_in   = 1'b0;
    assign mis_flag = 1'b0;

    // Forced alignment: drop the address bits below the access size
    always_comb begin
        case (size_q)
            2'(SZ_BYTE): off = alu_q[1:0];
            2'(SZ_HALF): off = {alu_q[1], 1'b0};
            default:     off = 2'b00;
        endcase
    end
`endif

    assign go_bus = (ex_load_i || ex_store_i) && !ex_excp_i && !mis_in;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (capture)       state_d = go_bus ? S_REQ : S_DONE;
            S_REQ:  if (dbus_gnt_i)    state_d = dbus_rvalid_i ? S_DONE : S_WAIT;
            S_WAIT: if (dbus_rvalid_i) state_d = S_DONE;
            S_DONE: if (WB_ready_i)    state_d = capture ? (go_bus ? S_REQ : S_DONE) : S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // FSM outputs: bus request phase and write-back valid
    always_comb begin
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = '0;
        dbus_wdata_o = '0;
        dbus_wstrb_o = '0;
        MEM_valid_o  = 1'b0;
        if (state_q == S_REQ) begin
            dbus_req_o  = 1'b1;
            dbus_we_o   = store_q;
            dbus_addr_o = {alu_q[XLEN-1:2], 2'b00};
            if (store_q) begin
                dbus_wdata_o = st_wdata;
                dbus_wstrb_o = st_wstrb;
            end
        end
        if (state_q == S_DONE) MEM_valid_o = data_valid_q;
    end

    // Bundle capture and bus response latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid_q <= 1'b0;
            pc_q         <= '0;
            alu_q        <= '0;
            rs2_q        <= '0;
            load_q       <= 1'b0;
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            wen_q        <= 1'b0;
            rd_q         <= 5'd0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else if (capture) begin
            data_valid_q <= 1'b1;
            pc_q         <= EX_pc_i;
            alu_q        <= ex_alu_res_i;
            rs2_q        <= ex_rs2_rdata_i;
            load_q       <= ex_load_i;
            store_q      <= ex_store_i;
            size_q       <= ex_size_i;
            uns_q        <= ex_unsigned_i;
            wen_q        <= ex_rd_wen_i;
            rd_q         <= ex_rd_idx_i;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (EX_ready_o) data_valid_q <= 1'b0;
            if (rsp_accept) begin
                rdata_q <= dbus_rdata_i;
                err_q   <= dbus_err_i;
            end
        end
    end

    // Store lane replication and byte strobes
    always_comb begin
        case (size_q)
            2'(SZ_BYTE): begin
                st_wdata = {(XLEN/8){rs2_q[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'(SZ_HALF): begin
                st_wdata = {(XLEN/16){rs2_q[15:0]}};
                st_wstrb = 4'b0011 << off;
            end
            default: begin
                st_wdata = rs2_q;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load alignment and sign/zero extension
    always_comb begin
        ld_shifted = rdata_q >> {off, 3'b000};
        case (size_q)
            2'(SZ_BYTE): ld_val = {{(XLEN-8){ld_shifted[7] & !uns_q}}, ld_shifted[7:0]};
            2'(SZ_HALF): ld_val = {{(XLEN-16){ld_shifted[15] & !uns_q}}, ld_shifted[15:0]};
            default:     ld_val = ld_shifted;
        endcase
    end

    // Write-back / forwarding bundle, zero while the stage is empty
    always_comb begin
        MEM_pc_o          = data_valid_q ? pc_q : '0;
        MEM_alu_res_o     = data_valid_q ? alu_q : '0;
        MEM_rd_idx_o      = data_valid_q ? rd_q : 5'd0;
        MEM_rd_wdata_o    = data_valid_q ? (load_q ? ld_val : alu_q) : '0;
        MEM_op_load_o     = data_valid_q && load_q;
        MEM_bus_err_o     = data_valid_q && err_q;
        MEM_rd_wen_o      = data_valid_q && wen_q && !err_q && !mis_flag;
        MEM_ld_misalign_o = data_valid_q && mis_flag && load_q;
        MEM_st_misalign_o = data_valid_q && mis_flag && store_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected write-back
// bundles plus a scripted data-bus responder.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_valid_i;
    logic [31:0] EX_pc_i, ex_alu_res_i, ex_rs2_rdata_i;
    logic        ex_load_i, ex_store_i, ex_unsigned_i, ex_rd_wen_i, ex_excp_i;
    logic [1:0]  ex_size_i;
    logic [4:0]  ex_rd_idx_i;
    logic        EX_ready_o;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_wstrb_o;
    logic        dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
    logic [31:0] dbus_rdata_i;
    logic        MEM_valid_o, WB_ready_i;
    logic [31:0] MEM_pc_o, MEM_alu_res_o, MEM_rd_wdata_o;
    logic        MEM_rd_wen_o, MEM_op_load_o, MEM_ld_misalign_o, MEM_st_misalign_o, MEM_bus_err_o;
    logic [4:0]  MEM_rd_idx_o;

    mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .EX_valid_i(EX_valid_i), .EX_pc_i(EX_pc_i), .ex_alu_res_i(ex_alu_res_i),
        .ex_rs2_rdata_i(ex_rs2_rdata_i), .ex_load_i(ex_load_i), .ex_store_i(ex_store_i),
        .ex_size_i(ex_size_i), .ex_unsigned_i(ex_unsigned_i), .ex_rd_wen_i(ex_rd_wen_i),
        .ex_rd_idx_i(ex_rd_idx_i), .ex_excp_i(ex_excp_i), .EX_ready_o(EX_ready_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_wstrb_o(dbus_wstrb_o), .dbus_gnt_i(dbus_gnt_i),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
        .MEM_valid_o(MEM_valid_o), .WB_ready_i(WB_ready_i), .MEM_pc_o(MEM_pc_o),
        .MEM_rd_wen_o(MEM_rd_wen_o), .MEM_rd_idx_o(MEM_rd_idx_o), .MEM_alu_res_o(MEM_alu_res_o),
        .MEM_rd_wdata_o(MEM_rd_wdata_o), .MEM_op_load_o(MEM_op_load_o),
        .MEM_ld_misalign_o(MEM_ld_misalign_o), .MEM_st_misalign_o(MEM_st_misalign_o),
        .MEM_bus_err_o(MEM_bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, alu, rs2, memword, exp_addr, exp_wdata;
        logic        load, store, uns, wen, excp, err;
        logic [1:0]  size;
        logic [4:0]  rd;
        logic [3:0]  exp_strb;
        int          gnt_dly, rv_dly;
    } txn_t;

    typedef struct {
        logic [31:0] pc, alu, rd_wdata;
        logic [4:0]  rd;
        logic        rd_wen, op_load, bus_err, ld_mis, st_mis, chk_wdata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_mis(input logic [1:0] size, input logic [1:0] a);
`ifdef MEM_MISALIGN_EXCP_EN
        return (size == 2'd1 && a[0]) || (size == 2'd2 && a != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] a,
                                             input logic [1:0] size, input logic uns);
        int off;
        logic [7:0]  b;
        logic [15:0] h;
        off = int'(a);
`ifndef MEM_MISALIGN_EXCP_EN
        if (size == 2'd1) off = int'(a) & 2;
        else if (size != 2'd0) off = 0;
`endif
        case (size)
            2'd0: begin b = word[off*8 +: 8];  return uns ? {24'd0, b} : {{24{b[7]}}, b}; end
            2'd1: begin h = word[off*8 +: 16]; return uns ? {16'd0, h} : {{16{h[15]}}, h}; end
            default: return word;
        endcase
    endfunction

    function automatic txn_t mk(input logic [31:0] pc, alu, rs2, input logic ld, st,
                                input logic [1:0] size, input logic uns, wen, input logic [4:0] rd,
                                input logic excp, input logic [31:0] memword, input logic err,
                                input int gd, rd_dly, input logic [31:0] ea, input logic [3:0] es,
                                input logic [31:0] ew);
        txn_t t;
        t.pc = pc; t.alu = alu; t.rs2 = rs2; t.load = ld; t.store = st; t.size = size;
        t.uns = uns; t.wen = wen; t.rd = rd; t.excp = excp; t.memword = memword; t.err = err;
        t.gnt_dly = gd; t.rv_dly = rd_dly; t.exp_addr = ea; t.exp_strb = es; t.exp_wdata = ew;
        return t;
    endfunction

    task automatic sb_pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("pc",       MEM_pc_o, e.pc);
        chk("alu_res",  MEM_alu_res_o, e.alu);
        chk("rd_idx",   32'(MEM_rd_idx_o), 32'(e.rd));
        chk("rd_wen",   32'(MEM_rd_wen_o), 32'(e.rd_wen));
        chk("op_load",  32'(MEM_op_load_o), 32'(e.op_load));
        chk("bus_err",  32'(MEM_bus_err_o), 32'(e.bus_err));
        chk("ld_mis",   32'(MEM_ld_misalign_o), 32'(e.ld_mis));
        chk("st_mis",   32'(MEM_st_misalign_o), 32'(e.st_mis));
        if (e.chk_wdata) chk("rd_wdata", MEM_rd_wdata_o, e.rd_wdata);
    endtask

    task automatic drive_ex(input txn_t t);
        bit rdy;
        rdy = 1'b0;
        EX_valid_i = 1'b1; EX_pc_i = t.pc; ex_alu_res_i = t.alu; ex_rs2_rdata_i = t.rs2;
        ex_load_i = t.load; ex_store_i = t.store; ex_size_i = t.size; ex_unsigned_i = t.uns;
        ex_rd_wen_i = t.wen; ex_rd_idx_i = t.rd; ex_excp_i = t.excp;
        for (int k = 0; k < 20 && !rdy; k++) begin
            @(negedge clk);
            rdy = EX_ready_o;
            @(posedge clk);
        end
        if (!rdy) chk("capture_timeout", 32'd0, 32'd1);
        #1 EX_valid_i = 1'b0;
    endtask

    task automatic run_txn(input txn_t t);
        exp_t e;
        bit   mis, breq;
        int   lat, req_cycles;
        mis  = (t.load || t.store) && is_mis(t.size, t.alu[1:0]);
        breq = (t.load || t.store) && !t.excp && !mis;
        e.pc = t.pc; e.alu = t.alu; e.rd = t.rd;
        e.rd_wen    = t.wen && !(breq && t.err) && !mis;
        e.op_load   = t.load;
        e.bus_err   = breq && t.err;
        e.ld_mis    = mis && t.load;
        e.st_mis    = mis && t.store;
        e.rd_wdata  = t.load ? exp_load(t.memword, t.alu[1:0], t.size, t.uns) : t.alu;
        e.chk_wdata = !t.load || breq;
        sb.push_back(e);
        drive_ex(t);
        @(negedge clk);
        lat = 0;
        req_cycles = 0;
        if (breq) begin
            chk("req_rise", 32'(dbus_req_o), 32'd1);
            for (int k = 0; k <= t.gnt_dly; k++) begin
                req_cycles += int'(dbus_req_o);
                chk("addr", dbus_addr_o, t.exp_addr);
                chk("we", 32'(dbus_we_o), 32'(t.store));
                chk("ex_ready_busy", 32'(EX_ready_o), 32'd0);
                chk("fwd_alu", MEM_alu_res_o, t.alu);
                if (t.store) begin
                    chk("wstrb", 32'(dbus_wstrb_o), 32'(t.exp_strb));
                    chk("wdata", dbus_wdata_o, t.exp_wdata);
                end
                if (k == t.gnt_dly) begin
                    dbus_gnt_i = 1'b1;
                    if (t.rv_dly == 0) begin
                        dbus_rvalid_i = 1'b1; dbus_rdata_i = t.memword; dbus_err_i = t.err;
                    end
                end
                @(posedge clk);
                #1 dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0;
                @(negedge clk);
                lat++;
            end
            chk("req_cycles", 32'(req_cycles), 32'(t.gnt_dly + 1));
            for (int j = 1; j <= t.rv_dly; j++) begin
                chk("req_after_gnt", 32'(dbus_req_o), 32'd0);
                if (j == t.rv_dly) begin
                    dbus_rvalid_i = 1'b1; dbus_rdata_i = t.memword; dbus_err_i = t.err;
                end
                @(posedge clk);
                #1 dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0;
                @(negedge clk);
                lat++;
            end
        end else begin
            chk("no_req", 32'(dbus_req_o), 32'd0);
        end
        for (int k = 0; k < 30 && !MEM_valid_o; k++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (MEM_valid_o) begin
            chk("latency", 32'(lat), breq ? 32'(t.gnt_dly + t.rv_dly + 1) : 32'd0);
            sb_pop_check();
        end else begin
            chk("mem_valid_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        txn_t t;
        exp_t e;
        rst = 1'b1; EX_valid_i = 1'b0; EX_pc_i = '0; ex_alu_res_i = '0; ex_rs2_rdata_i = '0;
        ex_load_i = 1'b0; ex_store_i = 1'b0; ex_size_i = 2'd0; ex_unsigned_i = 1'b0;
        ex_rd_wen_i = 1'b0; ex_rd_idx_i = 5'd0; ex_excp_i = 1'b0;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0; dbus_err_i = 1'b0;
        WB_ready_i = 1'b1;

        // reset state
        #2;
        chk("rst_ex_ready",  32'(EX_ready_o), 32'd1);
        chk("rst_req",       32'(dbus_req_o), 32'd0);
        chk("rst_mem_valid", 32'(MEM_valid_o), 32'd0);
        chk("rst_rd_wen",    32'(MEM_rd_wen_o), 32'd0);
        chk("rst_alu_res",   MEM_alu_res_o, 32'd0);
        chk("rst_addr",      dbus_addr_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ADD result, no bus access
        run_txn(mk(32'h100, 32'h1234, 32'h0, 0, 0, 2'd2, 0, 1, 5'd5, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0));

        // back-to-back ALU ops at one per cycle
        for (int i = 0; i < 3; i++) begin
            e.pc = 32'h200 + 32'(4*i); e.alu = 32'hA000 + 32'(i); e.rd = 5'(10 + i);
            e.rd_wen = 1'b1; e.op_load = 1'b0; e.bus_err = 1'b0; e.ld_mis = 1'b0;
            e.st_mis = 1'b0; e.rd_wdata = e.alu; e.chk_wdata = 1'b1;
            sb.push_back(e);
            EX_valid_i = 1'b1; EX_pc_i = e.pc; ex_alu_res_i = e.alu; ex_rd_idx_i = e.rd;
            ex_rd_wen_i = 1'b1; ex_load_i = 1'b0; ex_store_i = 1'b0; ex_size_i = 2'd2;
            @(negedge clk);
            chk("b2b_ready", 32'(EX_ready_o), 32'd1);
            if (i > 0) begin
                chk("b2b_valid", 32'(MEM_valid_o), 32'd1);
                if (MEM_valid_o) sb_pop_check();
            end
            @(posedge clk);
            #1;
        end
        EX_valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_valid_last", 32'(MEM_valid_o), 32'd1);
        if (MEM_valid_o) sb_pop_check();
        @(posedge clk);
        #1;

        // WB back-pressure holds the bundle
        t = mk(32'h300, 32'h5555, 32'h0, 0, 0, 2'd2, 0, 1, 5'd7, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        e.pc = t.pc; e.alu = t.alu; e.rd = t.rd; e.rd_wen = 1'b1; e.op_load = 1'b0;
        e.bus_err = 1'b0; e.ld_mis = 1'b0; e.st_mis = 1'b0; e.rd_wdata = t.alu; e.chk_wdata = 1'b1;
        sb.push_back(e);
        WB_ready_i = 1'b0;
        drive_ex(t);
        repeat (2) begin
            @(negedge clk);
            chk("stall_valid", 32'(MEM_valid_o), 32'd1);
            chk("stall_ready", 32'(EX_ready_o), 32'd0);
            chk("stall_alu",   MEM_alu_res_o, 32'h5555);
        end
        WB_ready_i = 1'b1;
        #1 sb_pop_check();
        @(posedge clk);
        #1;

        // LB / LBU at 0x1003, gnt+rvalid in the same cycle
        run_txn(mk(32'h400, 32'h1003, 32'h0, 1, 0, 2'd0, 0, 1, 5'd8, 0, 32'h80FFFFFF, 0, 0, 0, 32'h1000, 4'h0, 32'h0));
        run_txn(mk(32'h404, 32'h1003, 32'h0, 1, 0, 2'd0, 1, 1, 5'd9, 0, 32'h80FFFFFF, 0, 0, 0, 32'h1000, 4'h0, 32'h0));
        // SH with three gnt wait cycles
        run_txn(mk(32'h408, 32'h2002, 32'h0000ABCD, 0, 1, 2'd1, 0, 0, 5'd0, 0, 32'h0, 0, 3, 1, 32'h2000, 4'b1100, 32'hABCDABCD));
        // SB lane replication
        run_txn(mk(32'h40C, 32'h5001, 32'h12345678, 0, 1, 2'd0, 0, 0, 5'd0, 0, 32'h0, 0, 1, 1, 32'h5000, 4'b0010, 32'h78787878));
        // LH with two rvalid wait cycles
        run_txn(mk(32'h410, 32'h1006, 32'h0, 1, 0, 2'd1, 0, 1, 5'd11, 0, 32'h80017FFF, 0, 0, 2, 32'h1004, 4'h0, 32'h0));
        // LW with bus error
        run_txn(mk(32'h414, 32'h3000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd12, 0, 32'hDEADBEEF, 1, 0, 0, 32'h3000, 4'h0, 32'h0));
        // LW at 0x3002: misalign flag or forced alignment
        run_txn(mk(32'h418, 32'h3002, 32'h0, 1, 0, 2'd2, 0, 1, 5'd13, 0, 32'h11223344, 0, 1, 0, 32'h3000, 4'h0, 32'h0));
        // store with upstream exception skips the bus
        run_txn(mk(32'h41C, 32'h4001, 32'h99, 0, 1, 2'd0, 0, 0, 5'd0, 1, 32'h0, 0, 0, 0, 32'h4000, 4'h0, 32'h0));

        // reset while waiting for rvalid; late rvalid is ignored
        t = mk(32'h500, 32'h3000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd14, 0, 32'h0, 0, 0, 0, 32'h3000, 4'h0, 32'h0);
        drive_ex(t);
        @(negedge clk);
        chk("rw_req", 32'(dbus_req_o), 32'd1);
        dbus_gnt_i = 1'b1;
        @(posedge clk);
        #1 dbus_gnt_i = 1'b0;
        @(negedge clk);
        chk("rw_wait_valid", 32'(MEM_valid_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("rw_rst_ready", 32'(EX_ready_o), 32'd1);
        chk("rw_rst_rd_idx", 32'(MEM_rd_idx_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hCAFEF00D;
        @(posedge clk);
        #1 dbus_rvalid_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rw_valid", 32'(MEM_valid_o), 32'd0);
            chk("rw_req_idle", 32'(dbus_req_o), 32'd0);
            chk("rw_ready", 32'(EX_ready_o), 32'd1);
            chk("rw_wdata", MEM_rd_wdata_o, 32'd0);
        end
        @(posedge clk);
        #1;

        // stage still functional after the drop
        run_txn(mk(32'h600, 32'h0F0F, 32'h0, 0, 0, 2'd2, 0, 1, 5'd31, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0));

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the EX stage and upstream of WB. Registers the EX result bundle on a valid/ready handshake, performs at most one data-bus transaction per instruction through a req/gnt/rvalid handshake FSM, aligns and sign-extends load data, and presents the write-back bundle plus forwarding signals (`MEM_rd_wen_o`, `MEM_rd_idx_o`, `MEM_alu_res_o`) back to EX.

## Interface
- `XLEN`, 32, data/address width; byte lanes = XLEN/8 (only 32 supported).
- `clk` in 1, stage clock.
- `rst` in 1, asynchronous, active-high reset.
- `EX_valid_i` in 1, EX bundle valid.
- `EX_pc_i` in XLEN, instruction PC.
- `ex_alu_res_i` in XLEN, ALU result; effective address for load/store.
- `ex_rs2_rdata_i` in XLEN, store data (already forwarded).
- `ex_load_i` / `ex_store_i` in 1 each, memory op type (never both).
- `ex_size_i` in 2, 0=byte, 1=half, 2=word.
- `ex_unsigned_i` in 1, zero-extend load.
- `ex_rd_wen_i` in 1, `ex_rd_idx_i` in 5, destination.
- `ex_excp_i` in 1, exception already raised upstream (suppresses bus access).
- `EX_ready_o` out 1 -> EX `MEM_ready_i`.
- `dbus_req_o` out 1, `dbus_we_o` out 1, `dbus_addr_o` out XLEN (word-aligned), `dbus_wdata_o` out XLEN, `dbus_wstrb_o` out 4.
- `dbus_gnt_i` in 1, `dbus_rvalid_i` in 1, `dbus_rdata_i` in XLEN, `dbus_err_i` in 1 (qualified by rvalid).
- `MEM_valid_o` out 1, `WB_ready_i` in 1.
- `MEM_pc_o` out XLEN, `MEM_rd_wen_o` out 1, `MEM_rd_idx_o` out 5, `MEM_alu_res_o` out XLEN, `MEM_rd_wdata_o` out XLEN, `MEM_op_load_o` out 1, `MEM_ld_misalign_o` / `MEM_st_misalign_o` / `MEM_bus_err_o` out 1.

## Operation
- Capture: when `EX_ready_o && EX_valid_i`, all bundle fields are registered and `data_valid` <= 1; when `EX_ready_o && !EX_valid_i`, `data_valid` <= 0.
- All bundle outputs are ANDed with `data_valid`, so they read 0 when the stage is empty.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ on capture of a load/store with no upstream exception and no misalignment; any other capture -> DONE.
  - REQ: `dbus_req_o`=1, address/we/wdata/wstrb held stable; `dbus_gnt_i` -> WAIT.
  - WAIT: `dbus_rvalid_i` latches rdata and err -> DONE. An rvalid arriving in REQ in the same cycle as gnt is also accepted (REQ -> DONE).
  - DONE: if `WB_ready_i`, go to REQ/DONE/IDLE according to the newly captured bundle (or lack of one).
- `MEM_valid_o` = `data_valid` && state==DONE. `EX_ready_o` = !`data_valid` || (state==DONE && `WB_ready_i`).
- Store: `dbus_wdata_o` = rs2 replicated per size (byte x4, half x2); wstrb = 0001<<a[1:0] for byte, 0011<<a[1:0] for half, 1111 for word.
- Load: rdata is shifted right by 8*a[1:0], truncated to size, then sign- or zero-extended. `MEM_rd_wdata_o` = the load value for loads, otherwise `MEM_alu_res_o`.
- Bus error: `MEM_bus_err_o`=1 and `MEM_rd_wen_o` is forced to 0.
- Forwarding: `MEM_rd_wen_o`/`MEM_rd_idx_o`/`MEM_alu_res_o` are valid whenever `data_valid` is set. For loads, `MEM_op_load_o`=1 so the hazard unit stalls load-use.

## Timing
- Reset: FSM=IDLE, `data_valid`=0, every output 0 except `EX_ready_o`=1.
- Non-memory op: `MEM_valid_o` 1 cycle after capture; back-to-back throughput of 1 per cycle.
- Memory op: minimum 2 cycles from capture to `MEM_valid_o` (gnt and rvalid in the first REQ cycle); each gnt or rvalid wait cycle adds 1.
- An asynchronous reset during REQ/WAIT drops the transaction: `dbus_req_o` deasserts immediately, and late rvalid/gnt are ignored while in IDLE.
- `dbus_req_o` is never withdrawn before gnt; address/data never change while req=1.

## Configuration
- `MEM_MISALIGN_EXCP_EN` defined: a half access at an odd address, or a word access with a[1:0]!=0, sets `MEM_ld_misalign_o`/`MEM_st_misalign_o`, skips the bus, goes directly to DONE, and forces rd_wen to 0.
- Not defined: misalignment flags are tied to 0, and the low address bits are masked to the access size (forced alignment) before strobe and extract.

## Test plan
- ADD result 0x1234, rd=5, WB_ready=1 -> MEM_valid next cycle, rd_wdata=0x1234, rd_wen=1, dbus_req never asserted.
- LB at 0x1003, memory word 0x80FFFFFF, gnt+rvalid same cycle -> rd_wdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH rs2=0xABCD at 0x2002, gnt delayed 3 cycles -> req held for 4 cycles with stable addr=0x2000, wstrb=1100, wdata=0xABCDABCD; EX_ready=0 until DONE.
- LW at 0x3000 with rvalid and err=1 -> MEM_bus_err=1, rd_wen=0.
- LW at 0x3002 -> with `MEM_MISALIGN_EXCP_EN`: ld_misalign=1, no req; without it: req to 0x3000, wstrb unused, full-word load.
- Reset asserted in WAIT, rvalid one cycle later -> outputs 0, FSM stays IDLE, EX_ready=1.
